pll_lock_monitor: RTL and testbench

Digital lock and frequency monitor for the on-die analog delay-based PLL. It consumes the PLL output clock, which arrives asynchronously through a digital buffer. It counts rising edges of that clock over a fixed gate window of the system clock and compares the count against a programmed target. It reports frequency error and a debounced lock indication to the digital IO. It is the digital receive end of the PLL output path, in the same tile as the analog macro.

---
 rtl/pll_lock_monitor.sv | 165 ++++++++++++++++
 tb/tb_pll_lock_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// Frequency/lock monitor: counts synchronized PLL rising edges over a fixed clk window and debounces lock.
// Optional sticky loss-of-lock flag (clr_sticky/lol_sticky) is built when PLL_MON_STICKY_EN is defined.
module pll_lock_monitor #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 12,
  parameter int LOCK_COUNT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pll_clk_in,
  input  logic [CNT_W-1:0] target,
  input  logic [CNT_W-1:0] tol,
`ifdef PLL_MON_STICKY_EN
  input  logic             clr_sticky,
  output logic             lol_sticky,
`endif
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             too_fast,
  output logic             too_slow,
  output logic             overflow,
  output logic             locked
);

  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [3:0]       LOCK_N      = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, EVAL} state_t;

  logic             sync1_q, sync2_q, sync3_q;
  logic             pulse_det;
  state_t           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic             sat_q;
  logic [3:0]       good_cnt_q;
  logic [CNT_W-1:0] count_q;
  logic             cv_q, fast_q, slow_q, ovf_q, locked_q;
`ifdef PLL_MON_STICKY_EN
  logic             sticky_q;
`endif

  logic [CNT_W:0]   hi_lim_d, cnt_plus_tol_d;
  logic             too_fast_d, too_slow_d, in_tol_d;
  logic [3:0]       good_next_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= pll_clk_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign pulse_det = sync2_q & ~sync3_q;

  // One extra bit keeps target+tol and count+tol from wrapping.
  always_comb begin
    hi_lim_d       = {1'b0, target} + {1'b0, tol};
    cnt_plus_tol_d = {1'b0, edge_cnt_q} + {1'b0, tol};
    too_fast_d     = sat_q | ({1'b0, edge_cnt_q} > hi_lim_d);
    too_slow_d     = cnt_plus_tol_d < {1'b0, target};
    in_tol_d       = !too_fast_d && !too_slow_d;
    good_next_d    = (good_cnt_q == LOCK_N) ? good_cnt_q : good_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      good_cnt_q <= '0;
      count_q    <= '0;
      cv_q       <= 1'b0;
      fast_q     <= 1'b0;
      slow_q     <= 1'b0;
      ovf_q      <= 1'b0;
      locked_q   <= 1'b0;
`ifdef PLL_MON_STICKY_EN
      sticky_q   <= 1'b0;
`endif
    end else begin
      cv_q <= 1'b0;
      // Dropping enable mid-run discards the partial window; results hold.
      if (!enable && (state_q == SETTLE || state_q == MEASURE)) begin
        state_q    <= IDLE;
        good_cnt_q <= '0;
        locked_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (enable) begin
              state_q <= SETTLE;
              timer_q <= SETTLE_LOAD;
            end
          end
          SETTLE: begin
            if (timer_q == '0) begin
              state_q    <= MEASURE;
              timer_q    <= WINDOW_LOAD;
              edge_cnt_q <= '0;
              sat_q      <= 1'b0;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
          MEASURE: begin
            if (pulse_det) begin
              if (edge_cnt_q == CNT_MAX) sat_q <= 1'b1;
              else                       edge_cnt_q <= edge_cnt_q + 1'b1;
            end
            if (timer_q == '0) state_q <= EVAL;
            else               timer_q <= timer_q - 1'b1;
          end
          default: begin
            count_q <= edge_cnt_q;
            cv_q    <= 1'b1;
            fast_q  <= too_fast_d;
            slow_q  <= too_slow_d;
            ovf_q   <= sat_q;
            if (!enable) begin
              state_q    <= IDLE;
              good_cnt_q <= '0;
              locked_q   <= 1'b0;
            end else begin
              state_q    <= MEASURE;
              timer_q    <= WINDOW_LOAD;
              edge_cnt_q <= '0;
              sat_q      <= 1'b0;
              good_cnt_q <= in_tol_d ? good_next_d : 4'd0;
              locked_q   <= in_tol_d && (good_next_d == LOCK_N);
            end
          end
        endcase
      end
`ifdef PLL_MON_STICKY_EN
      // A loss seen in the same cycle as a clear still latches.
      if (state_q == EVAL && locked_q && !in_tol_d) sticky_q <= 1'b1;
      else if (clr_sticky)                          sticky_q <= 1'b0;
`endif
    end
  end

  assign count       = count_q;
  assign count_valid = cv_q;
  assign too_fast    = fast_q;
  assign too_slow    = slow_q;
  assign overflow    = ovf_q;
  assign locked      = locked_q;
`ifdef PLL_MON_STICKY_EN
  assign lol_sticky  = sticky_q;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: lock, drift, stuck input, abort, reset and a CNT_W=8 overflow instance.
module tb_pll_lock_monitor;

  localparam int WIN    = 1024;
  localparam int SETTLE = 16;
  localparam int FIRST  = SETTLE + WIN + 1;

  logic        clk, rst, enable, pll_clk_in;
  logic [11:0] target, tol, count;
  logic        count_valid, too_fast, too_slow, overflow, locked;
  logic        en2;
  logic [7:0]  target2, tol2, count2;
  logic        cv2, fast2, slow2, ovf2, locked2;
`ifdef PLL_MON_STICKY_EN
  logic        clr_sticky, lol_sticky, clr2, lol2;
`endif

  int hi_n, lo_n, ph;
  int checks, errors;

  pll_lock_monitor u_dut (
    .clk(clk), .rst(rst), .enable(enable), .pll_clk_in(pll_clk_in),
    .target(target), .tol(tol),
`ifdef PLL_MON_STICKY_EN
    .clr_sticky(clr_sticky), .lol_sticky(lol_sticky),
`endif
    .count(count), .count_valid(count_valid), .too_fast(too_fast),
    .too_slow(too_slow), .overflow(overflow), .locked(locked)
  );

  pll_lock_monitor #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .enable(en2), .pll_clk_in(pll_clk_in),
    .target(target2), .tol(tol2),
`ifdef PLL_MON_STICKY_EN
    .clr_sticky(clr2), .lol_sticky(lol2),
`endif
    .count(count2), .count_valid(cv2), .too_fast(fast2),
    .too_slow(slow2), .overflow(ovf2), .locked(locked2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PLL stand-in: high for hi_n clk cycles, low for lo_n; hi_n==0 holds it low.
  always @(negedge clk) begin
    if (hi_n == 0) begin
      pll_clk_in = 1'b0;
      ph = 0;
    end else begin
      ph = ph + 1;
      if (pll_clk_in && ph >= hi_n) begin
        pll_clk_in = 1'b0;
        ph = 0;
      end else if (!pll_clk_in && ph >= lo_n) begin
        pll_clk_in = 1'b1;
        ph = 0;
      end
    end
  end

  task automatic wait_cv(input bit sel, input int limit, output int n, output bit got);
    got = 1'b0;
    n = 0;
    while (!got && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      got = sel ? cv2 : count_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({count, count_valid, too_fast, too_slow, overflow, locked} !== 17'd0) begin errors++; $display("FAIL reset_outputs: got count=%0d cv=%b fast=%b slow=%b ovf=%b lock=%b want all 0", count, count_valid, too_fast, too_slow, overflow, locked); end
    checks++; if ({count2, cv2, fast2, slow2, ovf2, locked2} !== 13'd0) begin errors++; $display("FAIL reset_outputs8: got count=%0d cv=%b want all 0", count2, cv2); end
`ifdef PLL_MON_STICKY_EN
    checks++; if (lol_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b want 0", lol_sticky); end
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lock();
    int n; bit got;
    hi_n = 2; lo_n = 2;
    target = 12'd256; tol = 12'd4;
    repeat (8) @(posedge clk);
    #1;
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_cv(1'b0, 1200, n, got);
      checks++; if (!got) begin errors++; $display("FAIL lock_timeout[%0d]: no count_valid within %0d cycles", k, n); end
      if (k == 1) begin
        checks++; if (n - 1 !== FIRST) begin errors++; $display("FAIL lock_first_latency: got %0d want %0d", n - 1, FIRST); end
      end else begin
        checks++; if (n !== WIN + 1) begin errors++; $display("FAIL lock_spacing[%0d]: got %0d want %0d", k, n, WIN + 1); end
      end
      checks++; if (count !== 12'd256) begin errors++; $display("FAIL lock_count[%0d]: got %0d want 256", k, count); end
      checks++; if ({too_fast, too_slow, overflow} !== 3'b000) begin errors++; $display("FAIL lock_flags[%0d]: got fast=%b slow=%b ovf=%b want 0 0 0", k, too_fast, too_slow, overflow); end
      checks++; if (locked !== (k == 4)) begin errors++; $display("FAIL lock_locked[%0d]: got %b want %b", k, locked, k == 4); end
    end
  endtask

  task automatic test_drift();
    int n; bit got;
    hi_n = 2; lo_n = 3;
    wait_cv(1'b0, 1200, n, got);
    checks++; if (!got) begin errors++; $display("FAIL drift_timeout: no count_valid"); end
    checks++; if ({too_slow, locked} !== 2'b10) begin errors++; $display("FAIL drift_loss: got slow=%b locked=%b want 1 0", too_slow, locked); end
`ifdef PLL_MON_STICKY_EN
    checks++; if (lol_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set: got %b want 1", lol_sticky); end
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    checks++; if (lol_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b want 0", lol_sticky); end
`endif
    wait_cv(1'b0, 1200, n, got);
    checks++; if (!got) begin errors++; $display("FAIL drift_timeout2: no count_valid"); end
    checks++; if (count !== 12'd204 && count !== 12'd205) begin errors++; $display("FAIL drift_count: got %0d want 204 or 205", count); end
    checks++; if ({too_fast, too_slow, locked} !== 3'b010) begin errors++; $display("FAIL drift_flags: got fast=%b slow=%b locked=%b want 0 1 0", too_fast, too_slow, locked); end
    hi_n = 2; lo_n = 2;
    for (int k = 1; k <= 4; k++) begin
      wait_cv(1'b0, 1200, n, got);
      checks++; if (!got) begin errors++; $display("FAIL relock_timeout[%0d]: no count_valid", k); end
      checks++; if ({too_fast, too_slow} !== 2'b00) begin errors++; $display("FAIL relock_flags[%0d]: got fast=%b slow=%b want 0 0", k, too_fast, too_slow); end
      checks++; if (locked !== (k == 4)) begin errors++; $display("FAIL relock_locked[%0d]: got %b want %b", k, locked, k == 4); end
    end
  endtask

  task automatic test_stuck();
    int n; bit got;
    hi_n = 0;
    repeat (WIN) @(posedge clk);
    #1;
`ifdef PLL_MON_STICKY_EN
    clr_sticky = 1'b1;
`endif
    @(posedge clk);
    #1;
    checks++; if (count_valid !== 1'b1) begin errors++; $display("FAIL stuck_cv_timing: got cv=%b want 1", count_valid); end
    checks++; if ({too_slow, locked} !== 2'b10) begin errors++; $display("FAIL stuck_loss: got slow=%b locked=%b want 1 0", too_slow, locked); end
`ifdef PLL_MON_STICKY_EN
    checks++; if (lol_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set_wins: got %b want 1", lol_sticky); end
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    checks++; if (lol_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear2: got %b want 0", lol_sticky); end
`endif
    wait_cv(1'b0, 1200, n, got);
    checks++; if (!got) begin errors++; $display("FAIL stuck_timeout: no count_valid"); end
    checks++; if (count !== 12'd0) begin errors++; $display("FAIL stuck_count: got %0d want 0", count); end
    checks++; if ({too_fast, too_slow, overflow, locked} !== 4'b0100) begin errors++; $display("FAIL stuck_flags: got fast=%b slow=%b ovf=%b locked=%b want 0 1 0 0", too_fast, too_slow, overflow, locked); end
  endtask

  task automatic test_abort();
    int n, pulses; bit got;
    enable = 1'b0;
    hi_n = 2; lo_n = 2;
    repeat (4) @(posedge clk);
    #1;
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_cv(1'b0, 1200, n, got);
      checks++; if (!got) begin errors++; $display("FAIL abort_pre_timeout[%0d]: no count_valid", k); end
      if (k == 1) begin
        checks++; if (n - 1 !== FIRST) begin errors++; $display("FAIL abort_pre_latency: got %0d want %0d", n - 1, FIRST); end
      end
      checks++; if (locked !== (k == 4)) begin errors++; $display("FAIL abort_pre_locked[%0d]: got %b want %b", k, locked, k == 4); end
    end
    repeat (300) @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({count_valid, locked} !== 2'b00) begin errors++; $display("FAIL abort_clear: got cv=%b locked=%b want 0 0", count_valid, locked); end
    checks++; if (count !== 12'd256 || too_slow !== 1'b0) begin errors++; $display("FAIL abort_hold: got count=%0d slow=%b want 256 0", count, too_slow); end
    pulses = 0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      #1;
      if (count_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_cv: got %0d pulses want 0", pulses); end
    enable = 1'b1;
    wait_cv(1'b0, 1200, n, got);
    checks++; if (!got || n - 1 !== FIRST) begin errors++; $display("FAIL abort_restart_latency: got %0d want %0d", n - 1, FIRST); end
    checks++; if ({count, locked} !== {12'd256, 1'b0}) begin errors++; $display("FAIL abort_restart_result: got count=%0d locked=%b want 256 0", count, locked); end
  endtask

  task automatic test_reset_mid();
    int n; bit got;
    for (int k = 2; k <= 4; k++) begin
      wait_cv(1'b0, 1200, n, got);
      checks++; if (!got) begin errors++; $display("FAIL rmid_timeout[%0d]: no count_valid", k); end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rmid_prelock: got %b want 1", locked); end
    repeat (400) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if ({count, count_valid, too_fast, too_slow, overflow, locked} !== 17'd0) begin errors++; $display("FAIL rmid_outputs: got count=%0d cv=%b fast=%b slow=%b ovf=%b lock=%b want all 0", count, count_valid, too_fast, too_slow, overflow, locked); end
    wait_cv(1'b0, 1200, n, got);
    checks++; if (!got || n - 1 !== FIRST) begin errors++; $display("FAIL rmid_restart_latency: got %0d want %0d", n - 1, FIRST); end
    checks++; if (count !== 12'd256) begin errors++; $display("FAIL rmid_restart_count: got %0d want 256", count); end
  endtask

  task automatic test_overflow();
    int n; bit got;
    enable = 1'b0;
    hi_n = 1; lo_n = 1;
    target2 = 8'd200; tol2 = 8'd10;
    repeat (4) @(posedge clk);
    #1;
    en2 = 1'b1;
    wait_cv(1'b1, 1200, n, got);
    checks++; if (!got) begin errors++; $display("FAIL ovf_timeout: no count_valid"); end
    checks++; if (count2 !== 8'd255) begin errors++; $display("FAIL ovf_count: got %0d want 255", count2); end
    checks++; if ({ovf2, fast2, slow2, locked2} !== 4'b1100) begin errors++; $display("FAIL ovf_flags: got ovf=%b fast=%b slow=%b locked=%b want 1 1 0 0", ovf2, fast2, slow2, locked2); end
    en2 = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    hi_n = 0; lo_n = 0; ph = 0;
    pll_clk_in = 1'b0;
    rst = 1'b1; enable = 1'b0; en2 = 1'b0;
    target = '0; tol = '0; target2 = '0; tol2 = '0;
`ifdef PLL_MON_STICKY_EN
    clr_sticky = 1'b0; clr2 = 1'b0;
`endif
    #1;
    test_reset();
    test_lock();
    test_drift();
    test_stuck();
    test_abort();
    test_reset_mid();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
